// File: rtl/mole_game_core_if.sv
// Port bundle between the whack-a-mole core and its surroundings: debounced inputs and LFSR in,
// display and score outputs back.
interface mole_game_core_if #(
    parameter int unsigned N_HOLES = 8,
    parameter int unsigned SCORE_W = 8
);
    logic                 start;
    logic [15:0]          rand_in;
    logic [N_HOLES-1:0]   btn;
    logic [N_HOLES-1:0]   active;
    logic [N_HOLES-1:0]   lockout;
    logic [SCORE_W-1:0]   score;
    logic [SCORE_W-1:0]   misses;
    logic                 game_over;
    logic                 running;
    logic                 hit_pulse;
    logic                 miss_pulse;

    modport master (
        output start, rand_in, btn,
        input  active, lockout, score, misses, game_over, running, hit_pulse, miss_pulse
    );

    modport slave (
        input  start, rand_in, btn,
        output active, lockout, score, misses, game_over, running, hit_pulse, miss_pulse
    );
endinterface

// File: rtl/mole_game_core.sv
// Whack-a-mole game engine: spawns moles from the LFSR, ages them, scores hits and expiries,
// and locks out buttons that are pressed on an unlit hole.
module mole_game_core #(
    parameter int unsigned N_HOLES     = 8,
    parameter int unsigned MAX_ACTIVE  = 2,
    parameter int unsigned SCORE_W     = 8,
    parameter int unsigned GAME_CYCLES = 15_000_000,
    parameter int unsigned MOLE_CYCLES = 2_000_000,
    parameter int unsigned LOCK_CYCLES = 1_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    mole_game_core_if.slave bus
);

    localparam int unsigned IW     = (N_HOLES > 1) ? $clog2(N_HOLES) : 1;
    localparam int unsigned CNT_W  = $clog2(N_HOLES + 1);
    localparam int unsigned SUM_W  = SCORE_W + CNT_W;
    localparam int unsigned GAME_W = $clog2(GAME_CYCLES + 1);
    localparam int unsigned LIFE_W = $clog2(MOLE_CYCLES + 1);
    localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StRun, StOver} state_e;

    state_e               state_q, state_d;
    logic [N_HOLES-1:0]   active_q, active_d;
    logic [N_HOLES-1:0]   lockout_q, lockout_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [SCORE_W-1:0]   misses_q, misses_d;
    logic                 running_q, running_d;
    logic                 game_over_q, game_over_d;
    logic                 hit_pulse_q, hit_pulse_d;
    logic                 miss_pulse_q, miss_pulse_d;
    logic [GAME_W-1:0]    game_timer_q, game_timer_d;
    logic [LIFE_W-1:0]    life_q [N_HOLES];
    logic [LIFE_W-1:0]    life_d [N_HOLES];
    logic [LOCK_W-1:0]    lock_q [N_HOLES];
    logic [LOCK_W-1:0]    lock_d [N_HOLES];
    logic [N_HOLES-1:0]   btn_q;
    logic                 start_q;

    logic [N_HOLES-1:0]   rise;
    logic [N_HOLES-1:0]   hits;
    logic [N_HOLES-1:0]   wrong;
    logic [N_HOLES-1:0]   expire;
    logic                 start_rise;
    logic [IW-1:0]        spawn_idx;
    logic                 unused_rand;

    function automatic logic [CNT_W-1:0] popcount(input logic [N_HOLES-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_HOLES; i++) c = c + CNT_W'(v[i]);
        return c;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [CNT_W-1:0]   b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'({SCORE_W{1'b1}})) return {SCORE_W{1'b1}};
        return s[SCORE_W-1:0];
    endfunction

    // Locked buttons are masked here, so presses during a lockout never reach the game logic.
    assign rise        = bus.btn & ~btn_q & ~lockout_q;
    assign hits        = rise & active_q;
    assign wrong       = rise & ~active_q;
    assign start_rise  = bus.start & ~start_q;
    assign spawn_idx   = bus.rand_in[IW-1:0];
    assign unused_rand = ^bus.rand_in;

    // A hit on the same hole wins over its expiry.
    always_comb begin
        expire = '0;
        for (int i = 0; i < N_HOLES; i++) begin
            expire[i] = active_q[i] && (life_q[i] == LIFE_W'(1)) && !hits[i];
        end
    end

    always_comb begin
        state_d      = state_q;
        active_d     = active_q;
        lockout_d    = lockout_q;
        score_d      = score_q;
        misses_d     = misses_q;
        game_timer_d = game_timer_q;
        life_d       = life_q;
        lock_d       = lock_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;

        unique case (state_q)
            StIdle, StOver: begin
                if (start_rise) begin
                    state_d      = StRun;
                    score_d      = '0;
                    misses_d     = '0;
                    active_d     = '0;
                    lockout_d    = '0;
                    game_timer_d = GAME_W'(GAME_CYCLES);
                    for (int i = 0; i < N_HOLES; i++) begin
                        life_d[i] = '0;
                        lock_d[i] = '0;
                    end
                end
            end
            StRun: begin
                game_timer_d = game_timer_q - GAME_W'(1);
                if (game_timer_q == GAME_W'(1)) state_d = StOver;

                for (int i = 0; i < N_HOLES; i++) begin
                    if (hits[i] || expire[i]) begin
                        active_d[i] = 1'b0;
                    end else if (active_q[i]) begin
                        life_d[i] = life_q[i] - LIFE_W'(1);
                    end

                    if (wrong[i]) begin
                        lockout_d[i] = 1'b1;
                        lock_d[i]    = LOCK_W'(LOCK_CYCLES);
                    end else if (lockout_q[i]) begin
                        if (lock_q[i] == LOCK_W'(1)) lockout_d[i] = 1'b0;
                        lock_d[i] = lock_q[i] - LOCK_W'(1);
                    end
                end

                // Holes beyond N_HOLES never match, so out-of-range LFSR values skip the spawn.
                if (popcount(active_q) < CNT_W'(MAX_ACTIVE)) begin
                    for (int i = 0; i < N_HOLES; i++) begin
                        if (IW'(i) == spawn_idx && !active_q[i] && !hits[i] && !expire[i]) begin
                            active_d[i] = 1'b1;
                            life_d[i]   = LIFE_W'(MOLE_CYCLES);
                        end
                    end
                end

                score_d      = sat_add(score_q, popcount(hits));
                misses_d     = sat_add(misses_q, popcount(expire));
                hit_pulse_d  = |hits;
                miss_pulse_d = |expire;

                // Counts from the final cycle stand, but the board blanks on entering OVER.
                if (state_d == StOver) begin
                    active_d  = '0;
                    lockout_d = '1;
                end
            end
            default: state_d = StIdle;
        endcase

        running_d   = (state_d == StRun);
        game_over_d = (state_d == StOver);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            active_q     <= '0;
            lockout_q    <= '0;
            score_q      <= '0;
            misses_q     <= '0;
            running_q    <= 1'b0;
            game_over_q  <= 1'b0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            game_timer_q <= '0;
            btn_q        <= '0;
            start_q      <= 1'b0;
            for (int i = 0; i < N_HOLES; i++) begin
                life_q[i] <= '0;
                lock_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            lockout_q    <= lockout_d;
            score_q      <= score_d;
            misses_q     <= misses_d;
            running_q    <= running_d;
            game_over_q  <= game_over_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            game_timer_q <= game_timer_d;
            btn_q        <= bus.btn;
            start_q      <= bus.start;
            life_q       <= life_d;
            lock_q       <= lock_d;
        end
    end

    assign bus.active     = active_q;
    assign bus.lockout    = lockout_q;
    assign bus.score      = score_q;
    assign bus.misses     = misses_q;
    assign bus.running    = running_q;
    assign bus.game_over  = game_over_q;
    assign bus.hit_pulse  = hit_pulse_q;
    assign bus.miss_pulse = miss_pulse_q;

endmodule
